// File: rtl/psum_writeback_pkg.sv
// Shared configuration for the partial-sum write-back path: array geometry,
// accumulator/activation widths and the row types built from them.
package psum_writeback_pkg;

    localparam int CFG_SYS_COLS     = 3;
    localparam int CFG_P_BITWIDTH   = 32;
    localparam int CFG_ACC_BITWIDTH = 40;
    localparam int CFG_A_BITWIDTH   = 8;
    localparam int CFG_ACC_DEPTH    = 16;
    localparam int CFG_FIFO_DEPTH   = 4;

    typedef logic [CFG_SYS_COLS-1:0][CFG_P_BITWIDTH-1:0]   psum_row_t;
    typedef logic [CFG_SYS_COLS-1:0][CFG_ACC_BITWIDTH-1:0] acc_row_t;
    typedef logic [CFG_SYS_COLS-1:0][CFG_A_BITWIDTH-1:0]   act_row_t;

endpackage

// File: rtl/psum_writeback_if.sv
// Result-bus interface between the systolic array, the write-back block and
// the activation consumer. master = array/consumer side, slave = write-back.
interface psum_writeback_if #(
    parameter int SYS_COLS   = psum_writeback_pkg::CFG_SYS_COLS,
    parameter int P_BITWIDTH = psum_writeback_pkg::CFG_P_BITWIDTH,
    parameter int A_BITWIDTH = psum_writeback_pkg::CFG_A_BITWIDTH,
    parameter int ACC_DEPTH  = psum_writeback_pkg::CFG_ACC_DEPTH
);
    import psum_writeback_pkg::*;

    localparam int ROWS_W = $clog2(ACC_DEPTH) + 1;

    logic [SYS_COLS-1:0][P_BITWIDTH-1:0] psum_in;
    logic                                psum_valid;
    logic                                psum_ready;
    logic                                first_tile;
    logic                                last_tile;
    logic [ROWS_W-1:0]                   rows_cfg;
    logic [5:0]                          shift;
    logic [SYS_COLS-1:0][A_BITWIDTH-1:0] out_data;
    logic                                out_valid;
    logic                                out_ready;
    logic                                pass_done;

    modport master (
        output psum_in, psum_valid, first_tile, last_tile, rows_cfg, shift, out_ready,
        input  psum_ready, out_data, out_valid, pass_done
    );

    modport slave (
        input  psum_in, psum_valid, first_tile, last_tile, rows_cfg, shift, out_ready,
        output psum_ready, out_data, out_valid, pass_done
    );

endinterface

// File: rtl/psum_writeback_sync_fifo.sv
// Single-clock FIFO with occupancy count. Read data is forced to zero while
// empty. A push into a full FIFO is taken only when a pop happens alongside.
module psum_writeback_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty     = (count_r == CW'(0));
    assign full_s    = (count_r == CW'(DEPTH));
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full_s || do_pop_s);
    assign count     = count_r;
    assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array write port; contents are qualified by count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/psum_writeback.sv
// Partial-sum write-back: accumulates array result rows across K-tiles, and on
// the last tile requantizes (ReLU, arithmetic shift, unsigned clamp) into an
// output FIFO. Intake stalls early enough that the in-flight pipeline row
// always finds room in the FIFO.
module psum_writeback
    import psum_writeback_pkg::*;
#(
    parameter int SYS_COLS     = CFG_SYS_COLS,
    parameter int P_BITWIDTH   = CFG_P_BITWIDTH,
    parameter int ACC_BITWIDTH = CFG_ACC_BITWIDTH,
    parameter int A_BITWIDTH   = CFG_A_BITWIDTH,
    parameter int ACC_DEPTH    = CFG_ACC_DEPTH,
    parameter int FIFO_DEPTH   = CFG_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    psum_writeback_if.slave   bus
);
    localparam int PTR_W  = $clog2(ACC_DEPTH);
    localparam int ROWS_W = PTR_W + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int ROW_W  = SYS_COLS * A_BITWIDTH;

    typedef logic signed [ACC_BITWIDTH-1:0] acc_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_BITWIDTH-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_BITWIDTH-1){1'b0}}};

    acc_t              acc_r      [ACC_DEPTH][SYS_COLS];
    acc_t              acc_next_s [SYS_COLS];
    acc_t              pipe_r     [SYS_COLS];
    logic              pipe_valid_r;
    logic [5:0]        pipe_shift_r;
    logic [PTR_W-1:0]  ptr_r;
    logic [ROWS_W-1:0] rows_eff_s;
    logic              last_row_s;
    logic              accept_s;
    logic              pass_done_r;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_empty_s;
    logic              fifo_pop_s;
    logic [ROW_W-1:0]  fifo_wdata_s;
    logic [ROW_W-1:0]  fifo_rdata_s;

    // Signed add clamped to the accumulator range instead of wrapping.
    function automatic acc_t sat_add(input acc_t a, input acc_t b);
        logic [ACC_BITWIDTH:0] sum;
        sum = {a[ACC_BITWIDTH-1], a} + {b[ACC_BITWIDTH-1], b};
        if (sum[ACC_BITWIDTH] != sum[ACC_BITWIDTH-1]) begin
            sat_add = sum[ACC_BITWIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_add = sum[ACC_BITWIDTH-1:0];
        end
    endfunction

    // ReLU, arithmetic right shift, then clamp to the activation range.
    function automatic logic [A_BITWIDTH-1:0] quant(input acc_t v, input logic [5:0] sh);
        acc_t shifted;
        shifted = v >>> sh;
        if (v[ACC_BITWIDTH-1]) begin
            quant = '0;
        end else if (|shifted[ACC_BITWIDTH-1:A_BITWIDTH]) begin
            quant = '1;
        end else begin
            quant = shifted[A_BITWIDTH-1:0];
        end
    endfunction

    // A zero row count means a full-depth pass.
    assign rows_eff_s = (bus.rows_cfg == ROWS_W'(0)) ? ROWS_W'(ACC_DEPTH) : bus.rows_cfg;
    assign last_row_s = ({1'b0, ptr_r} == (rows_eff_s - ROWS_W'(1)));
    // Stall while the FIFO plus the pipeline row could not take another result.
    assign bus.psum_ready = (int'(fifo_count_s) + int'(pipe_valid_r)) < FIFO_DEPTH;
    assign accept_s       = bus.psum_valid && bus.psum_ready;

    // New accumulator row: overwrite on the first tile, saturating add otherwise.
    always_comb begin
        for (int c = 0; c < SYS_COLS; c++) begin
            acc_next_s[c] = bus.first_tile ? acc_t'($signed(bus.psum_in[c]))
                                           : sat_add(acc_r[ptr_r][c], acc_t'($signed(bus.psum_in[c])));
        end
    end

    // Accumulator bank update for the row under the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ACC_DEPTH; r++) begin
                for (int c = 0; c < SYS_COLS; c++) begin
                    acc_r[r][c] <= '0;
                end
            end
        end else if (accept_s) begin
            for (int c = 0; c < SYS_COLS; c++) begin
                acc_r[ptr_r][c] <= acc_next_s[c];
            end
        end
    end

    // Row pointer, end-of-pass pulse and the emit pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r        <= '0;
            pass_done_r  <= 1'b0;
            pipe_valid_r <= 1'b0;
            pipe_shift_r <= 6'd0;
            for (int c = 0; c < SYS_COLS; c++) begin
                pipe_r[c] <= '0;
            end
        end else begin
            pass_done_r  <= accept_s && last_row_s;
            pipe_valid_r <= accept_s && bus.last_tile;
            if (accept_s) begin
                ptr_r        <= last_row_s ? PTR_W'(0) : ptr_r + PTR_W'(1);
                pipe_shift_r <= bus.shift;
                for (int c = 0; c < SYS_COLS; c++) begin
                    pipe_r[c] <= acc_next_s[c];
                end
            end
        end
    end

    // Requantize the pipeline row on its way into the FIFO.
    always_comb begin
        fifo_wdata_s = '0;
        for (int c = 0; c < SYS_COLS; c++) begin
            fifo_wdata_s[c*A_BITWIDTH +: A_BITWIDTH] = quant(pipe_r[c], pipe_shift_r);
        end
    end

    assign fifo_pop_s = !fifo_empty_s && bus.out_ready;

    psum_writeback_sync_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_valid_r),
        .wdata (fifo_wdata_s),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    assign bus.out_data  = fifo_rdata_s;
    assign bus.out_valid = !fifo_empty_s;
    assign bus.pass_done = pass_done_r;

endmodule
